adc_s2mm_capture_ctrl: RTL

//  Sequences ADC capture into the AXI-Stream S2MM DMA input (S_AXIS_S2MM_0_*), in the adc_clock domain.
//  - Arms on request and waits for a software or external trigger.
//  - Packs both 14-bit ADC channels into 32-bit beats and frames them with tlast.
//  - Buffers beats in a small FIFO to absorb DMA backpressure. Flags overflow and counts frames.

---
 rtl/adc_capture_pkg.sv | 22 ++
 rtl/capture_fifo.sv | 55 +++++
 rtl/adc_s2mm_capture_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/adc_capture_pkg.sv
// Shared types and helpers for the ADC capture-to-S2MM path.
package adc_capture_pkg;

    localparam int unsigned AXIS_W    = 32;
    localparam logic [3:0]  TKEEP_ALL = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_FLUSH   = 3'd3,
        ST_DRAIN   = 3'd4
    } cap_state_e;

    // Sign-extend the low w bits of x to 16 bits (w in 1..16).
    function automatic logic [15:0] sext16(input logic [15:0] x, input int unsigned w);
        logic signed [15:0] t;
        t = signed'(x << (16 - w));
        return 16'(t >>> (16 - w));
    endfunction

endpackage

// File: rtl/capture_fifo.sv
// Synchronous first-word-fall-through FIFO with full/empty flags; head entry is presented directly.
module capture_fifo
    import adc_capture_pkg::*;
#(
    parameter int unsigned WIDTH = AXIS_W + 1,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) wptr_d = wptr_q + PTR_ONE;
        if (do_pop)  rptr_d = rptr_q + PTR_ONE;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/adc_s2mm_capture_ctrl.sv
// Triggered ADC capture sequencer feeding an AXI-Stream S2MM DMA through a small FWFT FIFO.
// Build option: define ADC_TEST_PATTERN_EN to replace ADC data with a frame/sample-count pattern.
module adc_s2mm_capture_ctrl
    import adc_capture_pkg::*;
#(
    parameter int unsigned DATA_W     = 14,
    parameter int unsigned LEN_W      = 16,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic              adc_clock,
    input  logic              rst,
    input  logic [DATA_W-1:0] adc_dat_a,
    input  logic [DATA_W-1:0] adc_dat_b,
    input  logic              adc_valid,
    input  logic              arm_i,
    input  logic              abort_i,
    input  logic              sw_trig_i,
    input  logic              ext_trig_i,
    input  logic              trig_sel,
    input  logic [LEN_W-1:0]  frame_len,
    input  logic [7:0]        n_frames,
    output logic [31:0]       m_tdata,
    output logic [3:0]        m_tkeep,
    output logic              m_tlast,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              busy_o,
    output logic              done_o,
    output logic              ovf_o,
    output logic [7:0]        frame_cnt_o
);

    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    cap_state_e         state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [7:0]         nfr_q, nfr_d;
    logic               tsel_q, tsel_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         fcnt_q, fcnt_d;
    logic               ovf_q, ovf_d;
    logic               done_q, done_d;
    logic [2:0]         sync_q;

    logic               fifo_push;
    logic [AXIS_W:0]    fifo_din;
    logic [AXIS_W:0]    fifo_dout;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_pop;
    logic               fifo_space;
    logic               ext_edge;
    logic               trig;
    logic               last_smp;
    logic [7:0]         fcnt_inc;
    logic [AXIS_W-1:0]  beat_data;

    assign ext_edge   = sync_q[1] && !sync_q[2];
    assign trig       = tsel_q ? ext_edge : sw_trig_i;
    assign fifo_pop   = !fifo_empty && m_tready;
    assign fifo_space = !fifo_full || fifo_pop;
    assign last_smp   = (cnt_q == len_q - LEN_ONE);
    assign fcnt_inc   = (fcnt_q == 8'hFF) ? fcnt_q : fcnt_q + 8'd1;

`ifdef ADC_TEST_PATTERN_EN
    assign beat_data = {16'hA5A5 ^ {8'h00, fcnt_q}, 16'(cnt_q)};
`else
    assign beat_data = {sext16(16'(adc_dat_b), DATA_W), sext16(16'(adc_dat_a), DATA_W)};
`endif

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        nfr_d     = nfr_q;
        tsel_d    = tsel_q;
        cnt_d     = cnt_q;
        fcnt_d    = fcnt_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;
        fifo_push = 1'b0;
        fifo_din  = '0;
        case (state_q)
            ST_IDLE: begin
                if (arm_i && !abort_i && (frame_len != '0)) begin
                    state_d = ST_ARMED;
                    len_d   = frame_len;
                    nfr_d   = n_frames;
                    tsel_d  = trig_sel;
                    cnt_d   = '0;
                    fcnt_d  = '0;
                    ovf_d   = 1'b0;
                end
            end
            ST_ARMED: begin
                if (abort_i)   state_d = ST_IDLE;
                else if (trig) state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (abort_i) begin
                    state_d = (cnt_q == '0) ? ST_DRAIN : ST_FLUSH;
                end else if (adc_valid) begin
                    if (fifo_space) begin
                        fifo_push = 1'b1;
                        fifo_din  = {last_smp, beat_data};
                        if (last_smp) begin
                            cnt_d   = '0;
                            fcnt_d  = fcnt_inc;
                            state_d = ((nfr_q != 8'd0) && (fcnt_inc == nfr_q)) ? ST_DRAIN : ST_ARMED;
                        end else begin
                            cnt_d = cnt_q + LEN_ONE;
                        end
                    end else begin
                        // Dropped samples leave the counter alone so frame length stays exact.
                        ovf_d = 1'b1;
                    end
                end
            end
            ST_FLUSH: begin
                if (fifo_space) begin
                    fifo_push = 1'b1;
                    fifo_din  = {1'b1, {AXIS_W{1'b0}}};
                    state_d   = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (fifo_empty) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge adc_clock or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            nfr_q   <= '0;
            tsel_q  <= 1'b0;
            cnt_q   <= '0;
            fcnt_q  <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            sync_q  <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            nfr_q   <= nfr_d;
            tsel_q  <= tsel_d;
            cnt_q   <= cnt_d;
            fcnt_q  <= fcnt_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            sync_q  <= {sync_q[1:0], ext_trig_i};
        end
    end

    capture_fifo #(
        .WIDTH (AXIS_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (adc_clock),
        .rst_i   (rst),
        .push_i  (fifo_push),
        .data_i  (fifo_din),
        .pop_i   (fifo_pop),
        .data_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign m_tdata     = fifo_dout[AXIS_W-1:0];
    assign m_tlast     = fifo_dout[AXIS_W];
    assign m_tvalid    = !fifo_empty;
    assign m_tkeep     = TKEEP_ALL;
    assign busy_o      = (state_q != ST_IDLE);
    assign done_o      = done_q;
    assign ovf_o       = ovf_q;
    assign frame_cnt_o = fcnt_q;

endmodule
